// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    // LSB-first frame: start(0), d0..d7, odd parity, stop(1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a registered falling-edge pulse.
module ps2_line_sync (
    input  logic clk,
    input  logic resetn,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;
    logic fall_reg;

    // Idle PS/2 lines are pulled high, so the chain resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
            fall_reg <= 1'b0;
        end else begin
            meta_reg <= line;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
            fall_reg <= prev_reg & ~sync_reg;
        end
    end

    assign level = sync_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked
// shift-out of one 11-bit frame, ACK sampling and line-idle wait, with a gap timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK_CPU,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       keyboard_clock_in,
    input  logic       keyboard_data_in,
    output logic       keyboard_clock_oe,
    output logic       keyboard_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic clk_level, clk_fall;
    logic data_level, data_fall;

    ps2_line_sync u_clock_sync (
        .clk    (CLK_CPU),
        .resetn (resetn),
        .line   (keyboard_clock_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (CLK_CPU),
        .resetn (resetn),
        .line   (keyboard_data_in),
        .level  (data_level),
        .fall   (data_fall)
    );

    ps2_tx_state_t             state_reg, state_next;
    logic [PS2_FRAME_BITS-1:0] shift_reg, shift_next;
    logic [3:0]                edge_reg, edge_next;
    logic [INH_W-1:0]          inh_reg, inh_next;
    logic [TMO_W-1:0]          tmo_reg, tmo_next;
    logic                      done_reg, done_next;
    logic                      error_reg, error_next;
    logic                      clock_oe_reg, clock_oe_next;
    logic                      data_oe_reg, data_oe_next;
    logic                      busy_reg, busy_next;

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            shift_reg    <= '1;
            edge_reg     <= '0;
            inh_reg      <= '0;
            tmo_reg      <= '0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            clock_oe_reg <= 1'b0;
            data_oe_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            edge_reg     <= edge_next;
            inh_reg      <= inh_next;
            tmo_reg      <= tmo_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            clock_oe_reg <= clock_oe_next;
            data_oe_reg  <= data_oe_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        edge_next  = edge_reg;
        inh_next   = inh_reg;
        tmo_next   = tmo_reg;
        done_next  = 1'b0;
        error_next = error_reg;

        unique case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    shift_next = ps2_frame(tx_data);
                    error_next = 1'b0;
                    inh_next   = '0;
                    state_next = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_reg == INH_LAST) state_next = REQ;
                else                     inh_next   = inh_reg + 1'b1;
            end
            REQ: begin
                edge_next  = '0;
                tmo_next   = '0;
                state_next = SEND;
            end
            SEND: begin
                if (tmo_reg == TMO_LAST) begin
                    error_next = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (clk_fall) begin
                    shift_next = {1'b1, shift_reg[PS2_FRAME_BITS-1:1]};
                    edge_next  = edge_reg + 4'd1;
                    tmo_next   = '0;
                    // Eleventh edge: the device drives data low to acknowledge.
                    if (edge_reg == 4'd10) begin
                        error_next = data_level;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (tmo_reg == TMO_LAST) begin
                    error_next = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (clk_level && data_level) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line drives are registered from the next state so they move with the state.
        clock_oe_next = (state_next == INHIBIT) || (state_next == REQ);
        data_oe_next  = (state_next == REQ) || ((state_next == SEND) && !shift_next[0]);
        busy_next     = (state_next != IDLE);
    end

    assign tx_ready          = (state_reg == IDLE);
    assign tx_done           = done_reg;
    assign tx_error          = error_reg;
    assign busy              = busy_reg;
    assign keyboard_clock_oe = clock_oe_reg;
    assign keyboard_data_oe  = data_oe_reg;

    // The data line's own falling edge is not needed by the transmitter.
    logic unused_data_fall;
    assign unused_data_fall = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;

    localparam int N_INH = 2500;
    localparam int N_TMO = 8000;
    localparam int HP    = 25;

    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_NOCLK = 2;
    localparam int M_RESET = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       clock_oe, data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       clk_line, data_line;
    logic       rst_req;

    assign clk_line  = ~(clock_oe | dev_clk_low);
    assign data_line = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(N_INH), .TIMEOUT_CYCLES(N_TMO)) dut (
        .CLK_CPU           (clk),
        .resetn            (resetn),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_done           (tx_done),
        .tx_error          (tx_error),
        .busy              (busy),
        .keyboard_clock_in (clk_line),
        .keyboard_data_in  (data_line),
        .keyboard_clock_oe (clock_oe),
        .keyboard_data_oe  (data_oe)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int done_count = 0;
    int last_done_cyc = 0;
    int acc_cyc = 0;
    bit last_exp_err = 1'b0;

    int         dev_mode_q[$];
    logic [10:0] dev_frame_q[$];
    bit         exp_err_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference frame from the protocol rules: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    // Scoreboard monitor: every tx_done pops one expectation.
    always @(negedge clk) begin
        if (tx_done) begin
            if (exp_err_q.size() == 0) begin
                chk("unexpected_done", 1'b0, 1, 0);
            end else begin
                bit e;
                e = exp_err_q.pop_front();
                chk("tx_error", tx_error == e, tx_error, e);
                chk("busy_at_done", busy == 1'b0, busy, 0);
                chk("oe_at_done", !clock_oe && !data_oe, {clock_oe, data_oe}, 0);
                $display("done: cycle %0d tx_error=%0b expected=%0b", cyc, tx_error, e);
                last_exp_err  = e;
                last_done_cyc = cyc;
                done_count++;
            end
        end
    end

    // Inhibit length monitor: clock held low with data released, right before the request.
    int inh_run = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            inh_run = 0;
        end else if (clock_oe && !data_oe) begin
            inh_run++;
        end else begin
            if (clock_oe && data_oe && inh_run != 0)
                chk("inhibit_len", inh_run == N_INH, inh_run, N_INH);
            inh_run = 0;
        end
    end

    // Device model: clocks the frame in, samples at the end of each high phase, then ACKs/NACKs.
    initial begin : device
        logic [10:0] got;
        logic [10:0] expf;
        int m;
        bit abort;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        rst_req      = 1'b0;
        forever begin
            wait (clock_oe === 1'b1);
            if (dev_mode_q.size() == 0) begin
                wait (busy === 1'b0);
                continue;
            end
            m    = dev_mode_q.pop_front();
            expf = dev_frame_q.pop_front();
            wait (clock_oe === 1'b0);
            if (m == M_NOCLK) begin
                wait (busy === 1'b0);
                continue;
            end
            repeat (HP) @(posedge clk);
            @(negedge clk);
            got   = '0;
            got[0] = data_line;
            abort = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                @(posedge clk);
                #1 dev_clk_low = 1'b1;
                if (m == M_RESET && i == 5) begin
                    repeat (6) @(posedge clk);
                    rst_req = 1'b1;
                    wait (resetn === 1'b0);
                    dev_clk_low = 1'b0;
                    rst_req     = 1'b0;
                    abort       = 1'b1;
                    break;
                end
                repeat (HP) @(posedge clk);
                #1 dev_clk_low = 1'b0;
                repeat (HP - 1) @(posedge clk);
                @(negedge clk);
                got[i] = data_line;
            end
            if (abort) continue;
            $display("frame: got %03h expected %03h", got, expf);
            chk("frame_bits", got == expf, got, expf);
            if (m == M_ACK) dev_data_low = 1'b1;
            repeat (5) @(posedge clk);
            #1 dev_clk_low = 1'b1;
            repeat (HP) @(posedge clk);
            #1 dev_clk_low = 1'b0;
            repeat (5) @(posedge clk);
            #1 dev_data_low = 1'b0;
        end
    end

    task automatic send(input logic [7:0] d, input int mode, input bit keep, input bit score);
        bit ok;
        dev_mode_q.push_back(mode);
        dev_frame_q.push_back(exp_frame(d));
        if (score) exp_err_q.push_back(mode == M_NACK || mode == M_NOCLK);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (tx_ready) begin
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!ok) chk("accept_timeout", 1'b0, 0, 1);
        $display("send: data=%02h mode=%0d accepted at cycle %0d", d, mode, acc_cyc);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (done_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 1'b0, done_count, target);
    endtask

    task automatic check_hold();
        repeat (5) @(negedge clk);
        chk("error_hold", tx_error == last_exp_err, tx_error, last_exp_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int target;
        int t0;
        int d0;
        bit ok;
        logic [7:0] d;
        resetn   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        target   = 0;
        repeat (4) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready == 1'b1, tx_ready, 1);
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_oe", !clock_oe && !data_oe, {clock_oe, data_oe}, 0);
        chk("rst_done", tx_done == 1'b0, tx_done, 0);
        chk("rst_error", tx_error == 1'b0, tx_error, 0);

        send(ps2_pkg::PS2_CMD_SET_LEDS, M_ACK, 1'b0, 1'b1);
        wait_done(++target);
        check_hold();

        send(8'h01, M_ACK, 1'b0, 1'b1);
        wait_done(++target);

        send(8'h3C, M_NACK, 1'b0, 1'b1);
        wait_done(++target);
        check_hold();

        send(8'h55, M_NOCLK, 1'b0, 1'b1);
        t0 = acc_cyc;
        wait_done(++target);
        chk("timeout_latency", last_done_cyc == t0 + 1 + N_INH + 1 + N_TMO,
            last_done_cyc - t0 - 1, N_INH + 1 + N_TMO);
        check_hold();

        send(ps2_pkg::PS2_CMD_RESET, M_ACK, 1'b1, 1'b1);
        send(ps2_pkg::PS2_CMD_ENABLE, M_ACK, 1'b0, 1'b1);
        target++;
        chk("b2b_accept", acc_cyc == last_done_cyc, acc_cyc, last_done_cyc);
        chk("b2b_first_done", done_count == target, done_count, target);
        wait_done(++target);

        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom_range(0, 255));
            send(d, ($urandom_range(0, 1) == 1) ? M_NACK : M_ACK, 1'b0, 1'b1);
            wait_done(++target);
        end

        send(8'hA5, M_RESET, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (rst_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("reset_point_timeout", 1'b0, 0, 1);
        d0 = done_count;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_oe", !clock_oe && !data_oe, {clock_oe, data_oe}, 0);
        chk("midrst_busy", busy == 1'b0, busy, 0);
        chk("midrst_ready", tx_ready == 1'b1, tx_ready, 1);
        chk("midrst_done", tx_done == 1'b0, tx_done, 0);
        chk("midrst_error", tx_error == 1'b0, tx_error, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (400) @(negedge clk);
        chk("postrst_ready", tx_ready == 1'b1, tx_ready, 1);
        chk("postrst_no_done", done_count == d0, done_count, d0);

        send(8'hC3, M_ACK, 1'b0, 1'b1);
        wait_done(++target);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_err_q.size() == 0, exp_err_q.size(), 0);
        chk("done_total", done_count == target, done_count, target);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
